// File: rtl/adder_pkg.sv
// Purpose : shared definitions for the shared adder / arbiter slice.
//           Holds the default sizing and the response-buffer state encoding.
// Contents: DEFAULT_WIDTH, DEFAULT_N_REQ, state_e (ST_EMPTY / ST_FULL).
package adder_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_N_REQ = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Purpose : combinational n-bit adder, carry-out in the MSB of sum.
// Ports   : x, y (n bits) operands; sum (n+1 bits) = x + y.
module carry_lookahead_adder #(
    parameter int n = 64
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    output logic [n:0]   sum
);

    always_comb begin
        logic [n-1:0] gen;
        logic [n-1:0] prop;
        logic         carry;
        gen   = x & y;
        prop  = x ^ y;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < n; i++) begin
            sum[i] = prop[i] ^ carry;
            carry  = gen[i] | (prop[i] & carry);
        end
        sum[n] = carry;
    end

endmodule

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// Purpose : round-robin priority search over a request vector.
// Ports   : req (N_REQ) request bits; rr_ptr (ID_W) index with highest
//           priority; grant (N_REQ) one-hot winner or zero; grant_idx (ID_W)
//           encoded winner; any_valid = |req.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_valid
);

    // Walk from lowest to highest priority so the highest-priority
    // match (offset 0 from rr_ptr) is the last to overwrite the result.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
        any_valid = |req;
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// Purpose : shares one carry_lookahead_adder among N_REQ requesters with
//           round-robin arbitration and a one-entry tagged response buffer.
// Ports   : clk, rst_n (async active-low)
//           req_valid/req_ready (N_REQ) per-requester handshake
//           req_x/req_y (N_REQ*WIDTH) operands, requester i at [i*WIDTH +: WIDTH]
//           rsp_valid/rsp_ready response handshake
//           rsp_sum (WIDTH+1) sum with carry-out, rsp_id (ID_W) requester tag
//           perf_ops/perf_stall (32) only when SHARED_ADDER_PERF_EN is defined
module shared_adder_arbiter
    import adder_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    input  logic [N_REQ*WIDTH-1:0] req_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH:0]         rsp_sum,
    output logic [ID_W-1:0]        rsp_id
`ifdef SHARED_ADDER_PERF_EN
    ,
    output logic [31:0]            perf_ops,
    output logic [31:0]            perf_stall
`endif
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH:0]    rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_valid;
    logic              can_accept;
    logic              accept;
    logic [WIDTH-1:0]  op_x, op_y;
    logic [WIDTH:0]    add_sum;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    always_comb begin
        op_x = req_x[int'(grant_idx)*WIDTH +: WIDTH];
        op_y = req_y[int'(grant_idx)*WIDTH +: WIDTH];
    end

    carry_lookahead_adder #(.n(WIDTH)) u_add (
        .x   (op_x),
        .y   (op_y),
        .sum (add_sum)
    );

    // rst_n gating keeps req_ready low while reset is held, even though
    // the state register already reads EMPTY.
    assign can_accept = rst_n & ((state_q == ST_EMPTY) | (rsp_ready & rsp_valid));
    assign req_ready  = grant & {N_REQ{can_accept}};
    assign accept     = any_valid & can_accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            rr_ptr_q  <= '0;
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
        if (accept) begin
            state_d   = ST_FULL;
            rsp_sum_d = add_sum;
            rsp_id_d  = grant_idx;
            rr_ptr_d  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end else if (state_q == ST_FULL && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Output logic
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
        rsp_sum   = rsp_sum_q;
        rsp_id    = rsp_id_q;
    end

`ifdef SHARED_ADDER_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (accept && perf_ops_q != '1) perf_ops_d = perf_ops_q + 32'd1;
        if (any_valid && !(|req_ready) && perf_stall_q != '1)
            perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter (N_REQ=4, WIDTH=64).
// Build with SHARED_ADDER_PERF_EN defined to also cover the perf counters.
module tb_shared_adder_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int IW = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W:0]       rsp_sum;
    logic [IW-1:0]    rsp_id;
`ifdef SHARED_ADDER_PERF_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_stall;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    shared_adder_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef SHARED_ADDER_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   sum;
    } vec_t;

    vec_t vecs[5];
    logic [W:0] rr_sum[N];

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[id*W +: W] = x;
        req_y[id*W +: W] = y;
    endtask

    initial begin
        logic [W:0] held_sum;

        vecs[0] = '{2, 64'd64, 64'd64, 65'd128};
        vecs[1] = '{0, 64'd123456, 64'd654321, 65'd777777};
        vecs[2] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE};
        vecs[3] = '{1, 64'd0, 64'd0, 65'd0};
        vecs[4] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000};
        rr_sum[0] = 65'd2000;
        rr_sum[1] = 65'd196;
        rr_sum[2] = 65'd808;
        rr_sum[3] = 65'd444444;

        // Reset state: ready must stay low even with all requesters valid
        rst_n     = 1'b0;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        step();
        step();
        check("reset_rsp_valid", 65'(rsp_valid), 65'd0);
        check("reset_rsp_sum",   rsp_sum, 65'd0);
        check("reset_rsp_id",    65'(rsp_id), 65'd0);
        check("reset_req_ready", 65'(req_ready), 65'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        step();
        check("idle_rsp_valid", 65'(rsp_valid), 65'd0);

        // Table: single requests, result one cycle after acceptance
        for (int i = 0; i < 5; i++) begin
            set_ops(vecs[i].id, vecs[i].x, vecs[i].y);
            req_valid = N'(1) << vecs[i].id;
            #2;
            check($sformatf("vec%0d_ready", i), 65'(req_ready), 65'(N'(1) << vecs[i].id));
            step();
            req_valid = '0;
            check($sformatf("vec%0d_valid", i), 65'(rsp_valid), 65'd1);
            check($sformatf("vec%0d_sum", i), rsp_sum, vecs[i].sum);
            check($sformatf("vec%0d_id", i), 65'(rsp_id), 65'(vecs[i].id));
        end

        // Reset while FULL: rsp_valid drops immediately, nothing reappears
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 65'(rsp_valid), 65'd0);
        check("midrst_req_ready", 65'(req_ready), 65'd0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        step();
        check("postrst_rsp_valid", 65'(rsp_valid), 65'd0);

        // Round robin: all valid continuously, grants 0,1,2,3,0
        set_ops(0, 64'd1000, 64'd1000);
        set_ops(1, 64'd123, 64'd73);
        set_ops(2, 64'd246, 64'd562);
        set_ops(3, 64'd112233, 64'd332211);
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            int g;
            g = c % N;
            #2;
            check($sformatf("rr%0d_ready", c), 65'(req_ready), 65'(N'(1) << g));
            step();
            check($sformatf("rr%0d_id", c), 65'(rsp_id), 65'(g));
            check($sformatf("rr%0d_sum", c), rsp_sum, rr_sum[g]);
        end

        // Backpressure: FULL and rsp_ready low for 5 cycles
        rsp_ready = 1'b0;
        held_sum  = rsp_sum;
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("bp%0d_ready", c), 65'(req_ready), 65'd0);
            step();
            check($sformatf("bp%0d_valid", c), 65'(rsp_valid), 65'd1);
            check($sformatf("bp%0d_sum", c), rsp_sum, 65'd2000);
            check($sformatf("bp%0d_id", c), 65'(rsp_id), 65'd0);
        end
        check("bp_sum_held", rsp_sum, held_sum);

        // Release: drain and accept on the same edge; pointer resumes at 1
        rsp_ready = 1'b1;
        #2;
        check("release_ready", 65'(req_ready), 65'b0010);
        step();
        req_valid = '0;
        check("release_valid", 65'(rsp_valid), 65'd1);
        check("release_id",    65'(rsp_id), 65'd1);
        check("release_sum",   rsp_sum, 65'd196);

`ifdef SHARED_ADDER_PERF_EN
        // Since the mid-op reset: 5 round-robin accepts + 1 release accept,
        // 5 backpressure stall cycles
        check("perf_ops",   65'(perf_ops),   65'd6);
        check("perf_stall", 65'(perf_stall), 65'd5);
`endif

        // Drain with no requests: back to EMPTY
        step();
        check("drain_valid", 65'(rsp_valid), 65'd0);
        step();
        check("idle2_valid", 65'(rsp_valid), 65'd0);
        check("idle2_sum_held", rsp_sum, 65'd196);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
